// File: rtl/adder.sv
// Registered two-level carry-lookahead adder: 4-bit lookahead groups, with a
// second lookahead level over the group (G,P) pairs. Result appears one cycle after the operands.
module adder #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] be_add_number,
   input  logic [WIDTH-1:0] add_number,
   input  logic             Cin,
   output logic [WIDTH-1:0] sum,
   output logic             Cout
);

   localparam int unsigned NumGroups = WIDTH / 4;

   logic [WIDTH-1:0]     g;
   logic [WIDTH-1:0]     p;
   logic [WIDTH-1:0]     c;
   logic [WIDTH-1:0]     sum_comb;
   logic [NumGroups-1:0] grp_g;
   logic [NumGroups-1:0] grp_p;
   logic [NumGroups:0]   grp_c;
   logic                 cout_comb;

   always_comb begin
      g = be_add_number & add_number;
      p = be_add_number ^ add_number;
   end

   // First level: each group's carries are flat sums of products of g, p and the group carry-in.
   for (genvar j = 0; j < NumGroups; j++) begin : gen_group
      localparam int unsigned B = 4 * j;

      always_comb begin
         grp_g[j] = g[B+3]
                  | (p[B+3] & g[B+2])
                  | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
         grp_p[j] = p[B+3] & p[B+2] & p[B+1] & p[B];
      end

      always_comb begin
         c[B]   = grp_c[j];
         c[B+1] = g[B] | (p[B] & grp_c[j]);
         c[B+2] = g[B+1]
                | (p[B+1] & g[B])
                | (p[B+1] & p[B] & grp_c[j]);
         c[B+3] = g[B+2]
                | (p[B+2] & g[B+1])
                | (p[B+2] & p[B+1] & g[B])
                | (p[B+2] & p[B+1] & p[B] & grp_c[j]);
      end
   end

   // Second level: every group carry-in is an independent product expansion over
   // the lower groups' (G,P), so no carry depends on another group's carry output.
   always_comb begin
      logic acc;
      logic term;
      acc      = 1'b0;
      term     = 1'b0;
      grp_c    = '0;
      grp_c[0] = Cin;
      for (int j = 0; j < NumGroups; j++) begin
         acc = 1'b0;
         for (int k = 0; k <= j; k++) begin
            term = grp_g[k];
            for (int m = k + 1; m <= j; m++) begin
               term = term & grp_p[m];
            end
            acc = acc | term;
         end
         term = Cin;
         for (int m = 0; m <= j; m++) begin
            term = term & grp_p[m];
         end
         grp_c[j+1] = acc | term;
      end
   end

   always_comb begin
      sum_comb  = p ^ c;
      cout_comb = grp_c[NumGroups];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum  <= '0;
         Cout <= 1'b0;
      end else begin
         sum  <= sum_comb;
         Cout <= cout_comb;
      end
   end

endmodule

// File: tb/tb_adder.sv
// Directed and exhaustive/random checks of adder at WIDTH=4 and WIDTH=16.
module tb_adder;

   logic        clk;
   logic        rst;
   logic [3:0]  a4, b4;
   logic        cin4;
   logic [3:0]  sum4;
   logic        cout4;
   logic [15:0] a16, b16;
   logic        cin16;
   logic [15:0] sum16;
   logic        cout16;

   int errors;
   int checks;

   adder #(.WIDTH(4)) dut4 (
      .clk           (clk),
      .rst           (rst),
      .be_add_number (a4),
      .add_number    (b4),
      .Cin           (cin4),
      .sum           (sum4),
      .Cout          (cout4)
   );

   adder #(.WIDTH(16)) dut16 (
      .clk           (clk),
      .rst           (rst),
      .be_add_number (a16),
      .add_number    (b16),
      .Cin           (cin16),
      .sum           (sum16),
      .Cout          (cout16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a4 = 4'b1111; b4 = 4'b0001; cin4 = 1'b1;
      a16 = 16'hffff; b16 = 16'h0001; cin16 = 1'b1;
      #3;
      checks++;
      if ({cout4, sum4} !== 5'b0_0000) begin
         errors++;
         $display("FAIL reset_async4: got %b required 00000", {cout4, sum4});
      end
      tick();
      checks++;
      if ({cout4, sum4} !== 5'b0_0000) begin
         errors++;
         $display("FAIL reset_edge4: got %b required 00000", {cout4, sum4});
      end
      checks++;
      if ({cout16, sum16} !== 17'h0) begin
         errors++;
         $display("FAIL reset_edge16: got %h required 00000", {cout16, sum16});
      end
      rst = 1'b0;
      // First edge after release loads the present inputs.
      tick();
      checks++;
      if ({cout4, sum4} !== 5'b1_0001) begin
         errors++;
         $display("FAIL reset_release4: got %b required 10001", {cout4, sum4});
      end
      checks++;
      if ({cout16, sum16} !== 17'h10001) begin
         errors++;
         $display("FAIL reset_release16: got %h required 10001", {cout16, sum16});
      end
   endtask

   task automatic test_basic();
      a4 = 4'b0000; b4 = 4'b0001; cin4 = 1'b0;
      tick();
      checks++;
      if ({cout4, sum4} !== 5'b0_0001) begin
         errors++;
         $display("FAIL basic_0p1: got %b required 00001", {cout4, sum4});
      end
      a4 = 4'b1111; b4 = 4'b0001; cin4 = 1'b0;
      tick();
      checks++;
      if ({cout4, sum4} !== 5'b1_0000) begin
         errors++;
         $display("FAIL carry_chain: got %b required 10000", {cout4, sum4});
      end
      a4 = 4'b0101; b4 = 4'b1010; cin4 = 1'b0;
      tick();
      checks++;
      if ({cout4, sum4} !== 5'b0_1111) begin
         errors++;
         $display("FAIL propagate_cin0: got %b required 01111", {cout4, sum4});
      end
      cin4 = 1'b1;
      tick();
      checks++;
      if ({cout4, sum4} !== 5'b1_0000) begin
         errors++;
         $display("FAIL propagate_cin1: got %b required 10000", {cout4, sum4});
      end
      a16 = 16'h5555; b16 = 16'haaaa; cin16 = 1'b1;
      tick();
      checks++;
      if ({cout16, sum16} !== 17'h10000) begin
         errors++;
         $display("FAIL propagate16: got %h required 10000", {cout16, sum16});
      end
   endtask

   task automatic test_back_to_back();
      a4 = 4'b0011; b4 = 4'b0100; cin4 = 1'b1;
      tick();
      checks++;
      if ({cout4, sum4} !== 5'b0_1000) begin
         errors++;
         $display("FAIL b2b_first: got %b required 01000", {cout4, sum4});
      end
      a4 = 4'b1000; b4 = 4'b1000; cin4 = 1'b0;
      tick();
      checks++;
      if ({cout4, sum4} !== 5'b1_0000) begin
         errors++;
         $display("FAIL b2b_second: got %b required 10000", {cout4, sum4});
      end
   endtask

   task automatic test_reset_mid();
      a4 = 4'b0101; b4 = 4'b1010; cin4 = 1'b0;
      tick();
      checks++;
      if ({cout4, sum4} !== 5'b0_1111) begin
         errors++;
         $display("FAIL mid_setup: got %b required 01111", {cout4, sum4});
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({cout4, sum4} !== 5'b0_0000) begin
         errors++;
         $display("FAIL mid_async: got %b required 00000", {cout4, sum4});
      end
      a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({cout4, sum4} !== 5'b0_0000) begin
            errors++;
            $display("FAIL mid_hold%0d: got %b required 00000", i, {cout4, sum4});
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({cout4, sum4} !== 5'b1_1111) begin
         errors++;
         $display("FAIL mid_release: got %b required 11111", {cout4, sum4});
      end
   endtask

   task automatic test_exhaustive4();
      logic [4:0] exp;
      for (int i = 0; i < 512; i++) begin
         a4   = i[3:0];
         b4   = i[7:4];
         cin4 = i[8];
         exp  = {1'b0, a4} + {1'b0, b4} + {4'b0000, cin4};
         tick();
         checks++;
         if ({cout4, sum4} !== exp) begin
            errors++;
            $display("FAIL exh4 a=%b b=%b cin=%b: got %b required %b",
                     a4, b4, cin4, {cout4, sum4}, exp);
         end
      end
   endtask

   task automatic test_random16();
      logic [16:0] exp;
      for (int i = 0; i < 300; i++) begin
         a16   = 16'($urandom);
         b16   = 16'($urandom);
         cin16 = 1'($urandom);
         if (i == 0) begin
            a16 = 16'hffff; b16 = 16'h0000; cin16 = 1'b1;
         end
         exp = {1'b0, a16} + {1'b0, b16} + {16'h0000, cin16};
         tick();
         checks++;
         if ({cout16, sum16} !== exp) begin
            errors++;
            $display("FAIL rand16 a=%h b=%h cin=%b: got %h required %h",
                     a16, b16, cin16, {cout16, sum16}, exp);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      a4 = '0; b4 = '0; cin4 = 1'b0;
      a16 = '0; b16 = '0; cin16 = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_reset_mid();
      test_exhaustive4();
      test_random16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, which sets the operand and sum width in bits; legal values are multiples of 4 from 4 to 32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port be_add_number, input, WIDTH bits: augend operand A, unsigned, bit WIDTH-1 is the MSB.
REQ-005 The module SHALL have port add_number, input, WIDTH bits: addend operand B, unsigned, bit WIDTH-1 is the MSB.
REQ-006 The module SHALL have port Cin, input, 1 bit: carry-in, weight 1.
REQ-007 The module SHALL have port sum, output, WIDTH bits: registered A+B+Cin modulo 2^WIDTH.
REQ-008 The module SHALL have port Cout, output, 1 bit: registered carry-out, weight 2^WIDTH.
REQ-009 The module SHALL have exactly one clock and one reset, with no other ports.

Function
REQ-010 The datapath SHALL compute the per-bit terms g[i]=A[i]&B[i] and p[i]=A[i]^B[i].
REQ-011 Carries SHALL be produced by carry-lookahead, not ripple: within each 4-bit group, c[i+1] is a flat sum-of-products of g, p and the group carry-in.
REQ-012 Each 4-bit group SHALL also produce a group generate G=g3|p3g2|p3p2g1|p3p2p1g0 and a group propagate P=p3&p2&p1&p0.
REQ-013 For WIDTH>4, the group carry-ins SHALL come from a second-level lookahead unit over the (G,P) pairs, seeded by Cin; no group carry may ripple from the previous group's sum logic.
REQ-014 The combinational sum SHALL be s[i]=p[i]^c[i], with c[0]=Cin.
REQ-015 The combinational carry-out SHALL be the carry out of the top group.
REQ-016 On every rising clk edge with rst low, sum and Cout SHALL load the combinational result of the current inputs; latency is exactly 1 cycle.
REQ-017 The inputs SHALL NOT be registered separately; a new operand pair is accepted every cycle (throughput 1/cycle).
REQ-018 Overflow SHALL wrap: when A+B+Cin >= 2^WIDTH, sum holds the low WIDTH bits and Cout=1.
REQ-019 An all-propagate case (A^B all ones) SHALL pass Cin straight to Cout with sum = ~Cin replicated, without glitch-dependent behaviour at the registered outputs.
REQ-020 The result SHALL be arithmetically identical to {Cout,sum} = A+B+Cin for every input combination.

Reset
REQ-021 While rst is high, sum SHALL be 0 and Cout SHALL be 0, immediately and independent of clk.
REQ-022 A rising clk edge while rst is high SHALL NOT load any value.
REQ-023 On the first rising clk edge after rst falls, the outputs SHALL load the result of the then-present inputs.
REQ-024 Asserting rst mid-stream SHALL discard the pending result; there is no other internal state to recover.

Verification
REQ-025 The bench SHALL check A=0000, B=0001, Cin=0, one clk -> sum=0001, Cout=0.
REQ-026 The bench SHALL check A=1111, B=0001, Cin=0, one clk -> sum=0000, Cout=1 (full carry chain).
REQ-027 The bench SHALL check A=0101, B=1010 at Cin=0 and at Cin=1 -> sum=1111, Cout=0, then sum=0000, Cout=1 (full propagate).
REQ-028 The bench SHALL check back-to-back operand pairs on consecutive cycles: A=0011, B=0100, Cin=1, then A=1000, B=1000, Cin=0 -> sum=1000, Cout=0 in cycle n+1, then sum=0000, Cout=1 in cycle n+2.
REQ-029 The bench SHALL check rst asserted between clock edges while sum=1111 -> sum=0000 and Cout=0 at once, and outputs held at 0 across edges until rst falls.
REQ-030 The bench SHALL check all 512 combinations of A, B and Cin at WIDTH=4, plus random vectors at WIDTH=16, against the reference A+B+Cin one cycle later.
